// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared N:1 select mux with valid/ready output.
// Optional per-grant burst limit enabled by defining MUX_ARB_BURST_EN.
module mux_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int SW        = $clog2(N),
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    gnt,
  output logic [SW-1:0]   sel,
  output logic [N-1:0]    ack,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  input  logic            o_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [SW-1:0] sel_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic          xfer;
  logic          found;
  logic [SW-1:0] winner;
  logic          release_gnt;

  // State register
  // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic
  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    found        = 1'b0;
    winner       = '0;
    release_gnt  = 1'b0;

    // Rotating priority search; SW-bit addition wraps modulo N since N is a power of 2.
    for (int i = 0; i < N; i++) begin
      if (!found && req[ptr + SW'(i)]) begin
        found  = 1'b1;
        winner = ptr + SW'(i);
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          gnt_nxt      = N'(1) << winner;
          sel_nxt      = winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          release_gnt = 1'b1;
        end else if (xfer) begin
          if (beat_cnt != CW'(MAX_BURST)) beat_cnt_nxt = beat_cnt + 1'b1;
`ifdef MUX_ARB_BURST_EN
          if (beat_cnt == CW'(MAX_BURST - 1)) release_gnt = 1'b1;
`endif
        end
        if (release_gnt) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_valid = (state == GRANT) && req[sel];
    xfer    = o_valid && o_ready;
    ack     = gnt & {N{xfer}};
    o_data  = din[sel*DW +: DW];
  end

endmodule
